// File: rtl/ifq_pkg.sv
// Shared definitions for the instruction-fetch path: address/line geometry
// and the instruction cache controller state encoding.
package ifq_pkg;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 128;
  localparam int INST_W = 32;
  localparam int OFFS_W = 4;

  typedef enum logic {
    IDLE      = 1'b0,
    MISS_WAIT = 1'b1
  } icache_state_e;

  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:OFFS_W], {OFFS_W{1'b0}}};
  endfunction

endpackage

// File: rtl/icache_line_store.sv
// Direct-mapped line storage: data, tag and valid arrays with combinational
// read and synchronous write/flush. Only the valid bits carry reset.
module icache_line_store
  import ifq_pkg::*;
#(
  parameter int NUM_LINES = 16,
  parameter int LINE_W    = ifq_pkg::LINE_W,
  parameter int IDX_W     = $clog2(NUM_LINES),
  parameter int TAG_W     = ifq_pkg::ADDR_W - ifq_pkg::OFFS_W - $clog2(NUM_LINES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic              rd_valid_o,
  output logic [TAG_W-1:0]  rd_tag_o,
  output logic [LINE_W-1:0] rd_data_o,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [TAG_W-1:0]  wr_tag_i,
  input  logic [LINE_W-1:0] wr_data_i,
  input  logic              flush_i
);

  logic [LINE_W-1:0]    data_q [NUM_LINES];
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q, valid_d;

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

  // Flush wins over a same-cycle refill so the freshly written line is dropped.
  always_comb begin
    valid_d = valid_q;
    if (wr_en_i) valid_d[wr_idx_i] = 1'b1;
    if (flush_i) valid_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      data_q[wr_idx_i] <= wr_data_i;
      tag_q[wr_idx_i]  <= wr_tag_i;
    end
  end

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller: hit returns the line the next
// cycle, miss issues a single refill request and waits for the memory reply.
//
// state     | meaning
// IDLE      | accepting fetch requests, hits answered next cycle
// MISS_WAIT | refill outstanding, new requests ignored
module icache_ctrl
  import ifq_pkg::*;
#(
  parameter int NUM_LINES = 16,
  parameter int LINE_W    = ifq_pkg::LINE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pc_in,
  input  logic              rd_en,
  input  logic              abort,
  input  logic              flush,
  output logic [LINE_W-1:0] Dout,
  output logic              Dout_valid,
  output logic [31:0]       mem_addr,
  output logic              mem_rd_req,
  input  logic [LINE_W-1:0] mem_rd_data,
  input  logic              mem_rd_valid,
  output logic              busy
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - OFFS_W - IDX_W;

  icache_state_e     state_q, state_d;
  logic [LINE_W-1:0] dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic              mem_rd_req_q, mem_rd_req_d;
  logic              cancel_q, cancel_d;

  logic [IDX_W-1:0]  lk_idx;
  logic [TAG_W-1:0]  lk_tag;
  logic              st_valid;
  logic [TAG_W-1:0]  st_tag;
  logic [LINE_W-1:0] st_data;
  logic              hit;
  logic              refill_we;
  logic              unused_offs;

  assign lk_idx      = pc_in[OFFS_W +: IDX_W];
  assign lk_tag      = pc_in[ADDR_W-1 -: TAG_W];
  assign unused_offs = ^pc_in[OFFS_W-1:0];

  // A flush in the lookup cycle forces a miss even if the line looks valid.
  assign hit = st_valid && (st_tag == lk_tag) && !flush;

  // The pending refill's index/tag come from the held mem_addr.
  icache_line_store #(
    .NUM_LINES (NUM_LINES),
    .LINE_W    (LINE_W),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W)
  ) u_store (
    .clk        (clk),
    .rst        (rst),
    .rd_idx_i   (lk_idx),
    .rd_valid_o (st_valid),
    .rd_tag_o   (st_tag),
    .rd_data_o  (st_data),
    .wr_en_i    (refill_we),
    .wr_idx_i   (mem_addr_q[OFFS_W +: IDX_W]),
    .wr_tag_i   (mem_addr_q[ADDR_W-1 -: TAG_W]),
    .wr_data_i  (mem_rd_data),
    .flush_i    (flush)
  );

  always_comb begin
    state_d      = state_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_rd_req_d = 1'b0;
    cancel_d     = cancel_q;
    refill_we    = 1'b0;
    case (state_q)
      IDLE: begin
        cancel_d = 1'b0;
        if (rd_en && !abort) begin
          if (hit) begin
            dout_d       = st_data;
            dout_valid_d = 1'b1;
          end else begin
            mem_addr_d   = line_align(pc_in);
            mem_rd_req_d = 1'b1;
            state_d      = MISS_WAIT;
          end
        end
      end
      MISS_WAIT: begin
        if (abort) cancel_d = 1'b1;
        if (mem_rd_valid) begin
          refill_we = 1'b1;
          state_d   = IDLE;
          cancel_d  = 1'b0;
          if (!(cancel_q || abort)) begin
            dout_d       = mem_rd_data;
            dout_valid_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      mem_addr_q   <= '0;
      mem_rd_req_q <= 1'b0;
      cancel_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      mem_addr_q   <= mem_addr_d;
      mem_rd_req_q <= mem_rd_req_d;
      cancel_q     <= cancel_d;
    end
  end

  assign Dout       = dout_q;
  assign Dout_valid = dout_valid_q;
  assign mem_addr   = mem_addr_q;
  assign mem_rd_req = mem_rd_req_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_icache_ctrl.sv
// Bench for icache_ctrl: directed scenarios followed by random traffic, all
// checked every cycle against a transaction-level cache model.
module tb_icache_ctrl;

  localparam int NL = 16;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   pc_in = '0;
  logic          rd_en = 1'b0;
  logic          abort = 1'b0;
  logic          flush = 1'b0;
  logic [LW-1:0] Dout;
  logic          Dout_valid;
  logic [31:0]   mem_addr;
  logic          mem_rd_req;
  logic [LW-1:0] mem_rd_data = '0;
  logic          mem_rd_valid = 1'b0;
  logic          busy;

  always #5 clk = ~clk;

  icache_ctrl #(.NUM_LINES(NL), .LINE_W(LW)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_in        (pc_in),
    .rd_en        (rd_en),
    .abort        (abort),
    .flush        (flush),
    .Dout         (Dout),
    .Dout_valid   (Dout_valid),
    .mem_addr     (mem_addr),
    .mem_rd_req   (mem_rd_req),
    .mem_rd_data  (mem_rd_data),
    .mem_rd_valid (mem_rd_valid),
    .busy         (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Cache contents and outstanding-miss bookkeeping, in line-address terms.
  bit            mv [NL];
  int unsigned   mt [NL];
  logic [LW-1:0] md [NL];
  bit            waiting   = 0;
  bit            cancelled = 0;
  int unsigned   pend_line = 0;
  int unsigned   ln, ix, tg;
  logic [LW-1:0] e_dout = '0;
  bit            e_dv = 0, e_req = 0, e_busy = 0;
  logic [31:0]   e_addr = '0;
  bit            started = 0;

  always @(posedge clk) begin
    started = 1;
    if (rst) begin
      for (int i = 0; i < NL; i++) mv[i] = 0;
      waiting = 0; cancelled = 0;
      e_dout = '0; e_dv = 0; e_req = 0; e_addr = '0;
    end else begin
      e_dv = 0; e_req = 0;
      if (!waiting) begin
        if (rd_en && !abort) begin
          ln = pc_in >> 4; ix = ln % NL; tg = ln / NL;
          if (!flush && mv[ix] && mt[ix] == tg) begin
            e_dout = md[ix]; e_dv = 1;
          end else begin
            e_req = 1; e_addr = ln << 4;
            waiting = 1; cancelled = 0; pend_line = ln;
          end
        end
      end else begin
        if (abort) cancelled = 1;
        if (mem_rd_valid) begin
          ix = pend_line % NL;
          mv[ix] = 1; mt[ix] = pend_line / NL; md[ix] = mem_rd_data;
          if (!cancelled) begin e_dout = mem_rd_data; e_dv = 1; end
          waiting = 0;
        end
      end
      if (flush) for (int i = 0; i < NL; i++) mv[i] = 0;
    end
    e_busy = waiting;
  end

  always @(posedge clk) begin
    #1;
    if (started) begin
      chk("dout_valid", 128'(Dout_valid), 128'(e_dv));
      chk("dout", Dout, e_dout);
      chk("mem_rd_req", 128'(mem_rd_req), 128'(e_req));
      chk("mem_addr", 128'(mem_addr), 128'(e_addr));
      chk("busy", 128'(busy), 128'(e_busy));
    end
  end

  // Memory responder: reply lat cycles after each refill request.
  int            resp_cnt = 0;
  int            fixed_lat = 0;
  bit            fixed_data_en = 0;
  logic [LW-1:0] fixed_data = '0;
  bit            spurious_en = 0;

  always @(negedge clk) begin
    mem_rd_valid = 1'b0;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        mem_rd_valid = 1'b1;
        mem_rd_data  = fixed_data_en ? fixed_data : {$urandom, $urandom, $urandom, $urandom};
      end
    end else if (spurious_en && !waiting && !mem_rd_req && $urandom_range(0, 15) == 0) begin
      mem_rd_valid = 1'b1;
      mem_rd_data  = {$urandom, $urandom, $urandom, $urandom};
    end
    if (mem_rd_req) resp_cnt = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4));
  end

  task automatic cyc(input bit r, input logic [31:0] pc, input bit ab, input bit fl, input bit rs);
    @(negedge clk);
    rd_en = r; pc_in = pc; abort = ab; flush = fl; rst = rs;
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    cyc(0, 32'h0, 0, 0, 0);
  endtask

  task automatic wait_idle(output int dvs);
    dvs = 0;
    for (int i = 0; i < 20 && busy; i++) begin
      idle();
      dvs += int'(Dout_valid);
    end
    chk("wait_idle", 128'(busy), 128'(0));
  endtask

  localparam logic [LW-1:0] D = 128'h0000000D_0000000C_0000000B_0000000A;

  initial begin
    int dvs, n;
    repeat (3) cyc(0, 32'h0, 0, 0, 1);
    chk("rst_dout_valid", 128'(Dout_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_mem_addr", 128'(mem_addr), 128'(0));
    chk("rst_dout", Dout, 128'(0));

    // cold miss, reply 3 cycles after the request pulse
    fixed_lat = 3; fixed_data_en = 1; fixed_data = D;
    cyc(1, 32'h0000_0104, 0, 0, 0);
    chk("cold_req", 128'(mem_rd_req), 128'(1));
    chk("cold_addr", 128'(mem_addr), 128'h100);
    chk("cold_busy", 128'(busy), 128'(1));
    n = 0;
    for (int i = 0; i < 10 && !Dout_valid; i++) begin
      idle();
      n++;
    end
    chk("cold_latency", 128'(n), 128'(4));
    chk("cold_dout", Dout, D);

    // hits
    cyc(1, 32'h0000_010C, 0, 0, 0);
    chk("hit_dv", 128'(Dout_valid), 128'(1));
    chk("hit_dout", Dout, D);
    chk("hit_noreq", 128'(mem_rd_req), 128'(0));
    dvs = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1, 32'h100 + 32'(4 * i), 0, 0, 0);
      dvs += int'(Dout_valid);
    end
    chk("hit_burst", 128'(dvs), 128'(4));
    idle();

    // conflict on index 0
    fixed_lat = 2; fixed_data_en = 0;
    cyc(1, 32'h0000_1100, 0, 0, 0);
    chk("conf_req", 128'(mem_rd_req), 128'(1));
    chk("conf_addr", 128'(mem_addr), 128'h1100);
    wait_idle(dvs);
    cyc(1, 32'h0000_0100, 0, 0, 0);
    chk("conf_remiss", 128'(mem_rd_req), 128'(1));
    wait_idle(dvs);

    // abort during refill, then same line hits
    cyc(1, 32'h0000_2040, 0, 0, 0);
    cyc(0, 32'h0, 1, 0, 0);
    wait_idle(dvs);
    chk("abort_no_dv", 128'(dvs), 128'(0));
    cyc(1, 32'h0000_2048, 0, 0, 0);
    chk("abort_then_hit", 128'(Dout_valid), 128'(1));
    chk("abort_hit_noreq", 128'(mem_rd_req), 128'(0));
    cyc(1, 32'h0000_5000, 1, 0, 0);
    chk("rdabort_dv", 128'(Dout_valid), 128'(0));
    chk("rdabort_req", 128'(mem_rd_req), 128'(0));

    // flush after two lines are filled
    cyc(0, 32'h0, 0, 1, 0);
    cyc(1, 32'h0000_0100, 0, 0, 0);
    chk("flush_miss_a", 128'(mem_rd_req), 128'(1));
    wait_idle(dvs);
    cyc(1, 32'h0000_2040, 0, 0, 0);
    chk("flush_miss_b", 128'(mem_rd_req), 128'(1));
    wait_idle(dvs);

    // flush in the refill cycle: response delivered, line not kept
    cyc(1, 32'h0000_3080, 0, 0, 0);
    idle();
    idle();
    cyc(0, 32'h0, 0, 1, 0);
    chk("flush_refill_dv", 128'(Dout_valid), 128'(1));
    cyc(1, 32'h0000_3080, 0, 0, 0);
    chk("flush_refill_remiss", 128'(mem_rd_req), 128'(1));
    wait_idle(dvs);

    // reset mid-miss, late reply ignored
    fixed_lat = 4;
    cyc(1, 32'h0000_40C0, 0, 0, 0);
    idle();
    cyc(0, 32'h0, 0, 0, 1);
    chk("rstmiss_dv", 128'(Dout_valid), 128'(0));
    chk("rstmiss_req", 128'(mem_rd_req), 128'(0));
    chk("rstmiss_addr", 128'(mem_addr), 128'(0));
    chk("rstmiss_busy", 128'(busy), 128'(0));
    chk("rstmiss_dout", Dout, 128'(0));
    dvs = 0; n = 0;
    for (int i = 0; i < 4; i++) begin
      idle();
      dvs += int'(Dout_valid);
      n += int'(busy);
    end
    chk("rstmiss_late_dv", 128'(dvs), 128'(0));
    chk("rstmiss_late_busy", 128'(n), 128'(0));
    cyc(1, 32'h0000_40C0, 0, 0, 0);
    chk("rstmiss_next_miss", 128'(mem_rd_req), 128'(1));
    wait_idle(dvs);

    // random traffic over a small address set to mix hits and conflicts
    fixed_lat = 0; spurious_en = 1;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] pc;
      pc = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 4) |
           32'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) pc |= 32'h8000_0000;
      cyc($urandom_range(0, 9) < 7, pc, $urandom_range(0, 19) == 0,
          $urandom_range(0, 49) == 0, $urandom_range(0, 199) == 0);
    end
    spurious_en = 0;
    repeat (6) idle();
    wait_idle(dvs);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
